// File: rtl/reg_bank_copy_engine.sv
// DEPTH x WIDTH register bank with two combinational read ports, one external
// write port and a sequenced block-copy engine with memmove ordering.
module reg_bank_copy_engine #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr_a,
    output logic [WIDTH-1:0] rd_data_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] rd_data_b,
    input  logic             cp_start,
    input  logic [AW-1:0]    cp_src,
    input  logic [AW-1:0]    cp_dst,
    input  logic [AW:0]      cp_len,
    output logic             cp_busy,
    output logic             cp_done,
    output logic             cp_err
);

    typedef enum logic [1:0] {S_IDLE, S_COPY, S_DONE} state_t;

    localparam logic [AW+1:0] LIMIT = (AW+2)'(DEPTH);

    state_t           state_q, state_d;
    logic [AW-1:0]    src_q, src_d, dst_q, dst_d;
    logic [AW:0]      len_q, len_d, cnt_q, cnt_d;
    logic             down_q, down_d;
    logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic [AW+1:0]    src_end, dst_end;
    logic [AW:0]      off;
    logic [AW-1:0]    cp_rd_addr, cp_wr_addr;
    logic             we;
    logic [AW-1:0]    waddr;
    logic [WIDTH-1:0] wdata;

    always_comb begin
        src_end = {2'b00, cp_src} + {1'b0, cp_len};
        dst_end = {2'b00, cp_dst} + {1'b0, cp_len};
        // DOWN walks from the top of the range so an overlapping dst above src never reads clobbered data
        off        = down_q ? (len_q - (AW+1)'(1) - cnt_q) : cnt_q;
        cp_rd_addr = src_q + off[AW-1:0];
        cp_wr_addr = dst_q + off[AW-1:0];

        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        down_d  = down_q;
        err_d   = 1'b0;
        we      = 1'b0;
        waddr   = wr_addr;
        wdata   = wr_data;

        case (state_q)
            S_IDLE: begin
                we = wr_en;
                if (cp_start) begin
                    if (cp_len == '0) begin
                        state_d = S_DONE;
                    end else if (src_end > LIMIT || dst_end > LIMIT) begin
                        err_d = 1'b1;
                    end else begin
                        src_d   = cp_src;
                        dst_d   = cp_dst;
                        len_d   = cp_len;
                        cnt_d   = '0;
                        down_d  = cp_dst > cp_src;
                        state_d = S_COPY;
                    end
                end
            end
            S_COPY: begin
                we    = 1'b1;
                waddr = cp_wr_addr;
                wdata = mem_q[cp_rd_addr];
                cnt_d = cnt_q + (AW+1)'(1);
                if (cnt_q == len_q - (AW+1)'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                we      = wr_en;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (ZERO_REG != 0 && waddr == '0) begin
            we = 1'b0;
        end

        busy_d = (state_d == S_COPY);
        done_d = (state_d == S_DONE);
    end

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            down_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            down_q  <= down_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            mem_q   <= mem_d;
        end
    end

    assign rd_data_a = (ZERO_REG != 0 && rd_addr_a == '0) ? '0 : mem_q[rd_addr_a];
    assign rd_data_b = (ZERO_REG != 0 && rd_addr_b == '0) ? '0 : mem_q[rd_addr_b];
    assign cp_busy   = busy_q;
    assign cp_done   = done_q;
    assign cp_err    = err_q;

endmodule

// File: tb/tb_reg_bank_copy_engine.sv
// Bench for reg_bank_copy_engine: transaction-level model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_reg_bank_copy_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [4:0]  rd_addr_a = '0;
    logic [4:0]  rd_addr_b = '0;
    logic [31:0] rd_data_a, rd_data_b;
    logic        cp_start = 1'b0;
    logic [4:0]  cp_src = '0;
    logic [4:0]  cp_dst = '0;
    logic [5:0]  cp_len = '0;
    logic        cp_busy, cp_done, cp_err;

    int errors = 0;
    int checks = 0;

    reg_bank_copy_engine dut (
        .clk(clk), .reset(reset),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
        .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
        .cp_start(cp_start), .cp_src(cp_src), .cp_dst(cp_dst), .cp_len(cp_len),
        .cp_busy(cp_busy), .cp_done(cp_done), .cp_err(cp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h t=%0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: memory array plus a queue of pending (dst, src) moves
    typedef struct { int dst; int src; } op_t;
    op_t         pend[$];
    logic [31:0] mmem [32];
    logic        e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;
    bit          armed = 1'b0;

    task automatic mwrite(input int a, input logic [31:0] v);
        if (a != 0) mmem[a] = v;
    endtask

    function automatic logic [31:0] mread(input logic [4:0] a);
        return (a == 5'd0) ? 32'h0 : mmem[a];
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mmem[i] = '0;
            pend.delete();
            e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0;
            armed  = 1'b1;
        end else if (armed) begin
            logic nd, ne;
            op_t  op;
            nd = 1'b0; ne = 1'b0;
            if (pend.size() > 0) begin
                op = pend.pop_front();
                mwrite(op.dst, mmem[op.src]);
                if (pend.size() == 0) nd = 1'b1;
            end else begin
                if (wr_en) mwrite(int'(wr_addr), wr_data);
                if (!e_done && cp_start) begin
                    if (cp_len == 6'd0) nd = 1'b1;
                    else if (int'(cp_src) + int'(cp_len) > 32 || int'(cp_dst) + int'(cp_len) > 32) ne = 1'b1;
                    else begin
                        for (int k = 0; k < int'(cp_len); k++) begin
                            if (cp_dst > cp_src)
                                op = '{dst: int'(cp_dst) + int'(cp_len) - 1 - k, src: int'(cp_src) + int'(cp_len) - 1 - k};
                            else
                                op = '{dst: int'(cp_dst) + k, src: int'(cp_src) + k};
                            pend.push_back(op);
                        end
                    end
                end
            end
            e_busy = pend.size() > 0;
            e_done = nd;
            e_err  = ne;
        end
        #1;
        if (armed) begin
            chk("m_busy", cp_busy, e_busy);
            chk("m_done", cp_done, e_done);
            chk("m_err",  cp_err,  e_err);
            chk("m_rd_a", rd_data_a, mread(rd_addr_a));
            chk("m_rd_b", rd_data_b, mread(rd_addr_b));
        end
    end

    task automatic wr(input logic [4:0] a, input logic [31:0] v);
        @(negedge clk); wr_en = 1'b1; wr_addr = a; wr_data = v;
        @(negedge clk); wr_en = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [4:0] a, input logic [31:0] exp);
        @(negedge clk); rd_addr_b = a;
        #1 chk(nm, rd_data_b, exp);
    endtask

    task automatic do_copy(input logic [4:0] s, input logic [4:0] d, input logic [5:0] n,
                           output int cyc, output int bcnt);
        bit found;
        @(negedge clk); cp_start = 1'b1; cp_src = s; cp_dst = d; cp_len = n;
        @(negedge clk); cp_start = 1'b0;
        cyc = 0; bcnt = 0; found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            cyc = i + 1;
            if (cp_done) found = 1;
            else begin
                if (cp_busy) bcnt++;
                @(negedge clk);
            end
        end
        chk("copy_finish", 32'(found), 32'd1);
    endtask

    task automatic err_try(input string nm, input logic [4:0] s, input logic [4:0] d, input logic [5:0] n);
        @(negedge clk); cp_start = 1'b1; cp_src = s; cp_dst = d; cp_len = n;
        @(negedge clk); cp_start = 1'b0;
        chk({nm, "_pulse"}, 32'(cp_err), 32'd1);
        chk({nm, "_busy"},  32'(cp_busy), 32'd0);
        @(negedge clk);
        chk({nm, "_single"}, 32'(cp_err), 32'd0);
    endtask

    logic [31:0] exp6 [6];
    int cyc, bc;

    initial begin
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset_busy", 32'(cp_busy), 32'd0);
        chk("reset_done", 32'(cp_done), 32'd0);
        rd_chk("reset_r7", 5'd7, 32'h0);

        // Basic UP copy
        for (int i = 0; i < 4; i++) wr(5'(4 + i), 32'hA0 + 32'(i));
        do_copy(5'd4, 5'd16, 6'd4, cyc, bc);
        chk("up_busy_cycles", 32'(bc), 32'd4);
        chk("up_done_latency", 32'(cyc), 32'd5);
        for (int i = 0; i < 4; i++) begin
            rd_chk("up_dst", 5'(16 + i), 32'hA0 + 32'(i));
            rd_chk("up_src", 5'(4 + i), 32'hA0 + 32'(i));
        end

        // Overlap, dst above src (DOWN)
        for (int i = 0; i < 4; i++) wr(5'(8 + i), 32'(i + 1));
        do_copy(5'd8, 5'd10, 6'd4, cyc, bc);
        exp6 = '{32'd1, 32'd2, 32'd1, 32'd2, 32'd3, 32'd4};
        for (int i = 0; i < 6; i++) rd_chk("down_ovl", 5'(8 + i), exp6[i]);

        // Overlap, dst below src (UP)
        for (int i = 0; i < 4; i++) wr(5'(8 + i), 32'(i + 1));
        wr(5'd12, 32'h12);
        wr(5'd13, 32'h13);
        do_copy(5'd10, 5'd8, 6'd4, cyc, bc);
        exp6 = '{32'd3, 32'd4, 32'h12, 32'h13, 32'h12, 32'h13};
        for (int i = 0; i < 6; i++) rd_chk("up_ovl", 5'(8 + i), exp6[i]);

        // Rejected requests
        err_try("err_src", 5'd30, 5'd0, 6'd3);
        err_try("err_dst", 5'd0, 5'd31, 6'd2);
        rd_chk("err_r4", 5'd4, 32'hA0);

        // Zero length and full-bank self copy
        do_copy(5'd3, 5'd9, 6'd0, cyc, bc);
        chk("len0_latency", 32'(cyc), 32'd1);
        chk("len0_busy", 32'(bc), 32'd0);
        do_copy(5'd0, 5'd0, 6'd32, cyc, bc);
        chk("full_latency", 32'(cyc), 32'd33);
        chk("full_busy", 32'(bc), 32'd32);
        rd_chk("full_r16", 5'd16, 32'hA0);

        // Contention: external write and start during a copy are dropped
        wr(5'd20, 32'h20);
        @(negedge clk); cp_start = 1'b1; cp_src = 5'd4; cp_dst = 5'd24; cp_len = 6'd4;
        @(negedge clk); cp_start = 1'b0;
        @(negedge clk);
        chk("cont_busy", 32'(cp_busy), 32'd1);
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'hDEAD;
        cp_start = 1'b1; cp_src = 5'd0; cp_dst = 5'd1; cp_len = 6'd1;
        @(negedge clk); wr_en = 1'b0; cp_start = 1'b0;
        for (int i = 0; i < 50 && !cp_done; i++) @(negedge clk);
        chk("cont_done", 32'(cp_done), 32'd1);
        rd_chk("cont_r20", 5'd20, 32'h20);
        rd_chk("cont_r24", 5'd24, 32'hA0);
        rd_chk("cont_r27", 5'd27, 32'hA3);
        wr(5'd20, 32'hDEAD);
        rd_chk("idle_wr_r20", 5'd20, 32'hDEAD);

        // Reset after the third write of an 8-register copy
        @(negedge clk); cp_start = 1'b1; cp_src = 5'd4; cp_dst = 5'd16; cp_len = 6'd8;
        @(negedge clk); cp_start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_busy", 32'(cp_busy), 32'd0);
        chk("rst_done", 32'(cp_done), 32'd0);
        rd_addr_a = 5'd4; rd_addr_b = 5'd16;
        #1;
        chk("rst_r4", rd_data_a, 32'h0);
        chk("rst_r16", rd_data_b, 32'h0);
        @(negedge clk);
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("rst_no_done", 32'(cp_done), 32'd0);
        end

        // Register 0 is hard-wired to zero
        wr(5'd5, 32'h55);
        wr(5'd6, 32'h66);
        wr(5'd0, 32'h77);
        rd_chk("zr_ext_r0", 5'd0, 32'h0);
        do_copy(5'd5, 5'd0, 6'd2, cyc, bc);
        chk("zr_latency", 32'(cyc), 32'd3);
        rd_chk("zr_r0", 5'd0, 32'h0);
        rd_chk("zr_r1", 5'd1, 32'h66);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
